// File: rtl/seq_store_pkg.sv
// Shared state encodings and colour names for the Simon Says sequence store.
package seq_store_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, CHECK = 2'd2} seq_state_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  typedef enum logic [1:0] {RED = 2'd0, GREEN = 2'd1, BLUE = 2'd2, YELLOW = 2'd3} colour_t;

endpackage

// File: rtl/seq_ptr_ctr.sv
// Modulo-DEPTH pointer with synchronous clear, increment and a combinational wrap flag.
module seq_ptr_ctr #(
  parameter int unsigned DEPTH = 33,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] ptr,
  output logic             wrap_c
);

  assign wrap_c = inc && (ptr == CNT_W'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= wrap_c ? '0 : ptr + CNT_W'(1);
    end
  end

endmodule

// File: rtl/segment_sequence_store.sv
// Colour sequence store with valid/ready playback and step-by-step press checking.
// Optional SEQ_WRAP_EN: circular memory where a load while full overwrites the oldest entry.
module segment_sequence_store
  import seq_store_pkg::*;
#(
  parameter int unsigned DEPTH    = 33,
  parameter int unsigned COLOUR_W = 2,
  parameter int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load_colour,
  input  logic [COLOUR_W-1:0]         new_colour,
  input  logic                        play_start,
  output logic                        play_valid,
  input  logic                        play_ready,
  output logic [COLOUR_W-1:0]         play_colour,
  output logic                        play_last,
  input  logic                        check_start,
  input  logic                        check_valid,
  input  logic [COLOUR_W-1:0]         check_colour,
  output logic                        check_match,
  output logic                        check_mismatch,
  output logic                        check_done,
  output logic [CNT_W-1:0]            seq_len,
  output logic                        full,
  output logic                        overflow,
  output logic [DEPTH*COLOUR_W-1:0]   segment
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [1:0]          state, state_nxt;
  logic [COLOUR_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]    head, rd_ptr, rd_idx, wr_idx;
  logic                head_wrap, rd_wrap, unused_wrap;
  logic                idle, go_play, go_check, load_ok, mem_we, head_inc;
  logic                last, beat, press, hit;

  // Physical slot of logical offset b from head; both operands are below DEPTH+1.
  function automatic logic [CNT_W-1:0] add_mod(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s >= SUM_W'(DEPTH)) s = s - SUM_W'(DEPTH);
    return s[CNT_W-1:0];
  endfunction

  assign idle     = (state == ST_IDLE);
  assign full     = (seq_len == CNT_W'(DEPTH));
  assign go_play  = idle && play_start && (seq_len != '0);
  assign go_check = idle && check_start && (seq_len != '0) && !go_play;
  assign load_ok  = idle && load_colour && !go_play && !go_check;

`ifdef SEQ_WRAP_EN
  assign mem_we   = load_ok;
  assign head_inc = load_ok && full;
`else
  assign mem_we   = load_ok && !full;
  assign head_inc = 1'b0;
`endif

  assign rd_idx      = add_mod(head, rd_ptr);
  assign wr_idx      = add_mod(head, seq_len);
  assign last        = (rd_ptr == seq_len - CNT_W'(1));
  assign play_valid  = (state == ST_PLAY);
  assign play_colour = mem[rd_idx[IDX_W-1:0]];
  assign play_last   = play_valid && last;
  assign beat        = play_valid && play_ready;
  assign press       = (state == ST_CHECK) && check_valid;
  assign hit         = (check_colour == mem[rd_idx[IDX_W-1:0]]);
  assign unused_wrap = head_wrap ^ rd_wrap;

  seq_ptr_ctr #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_head (
    .clk(clk), .reset(reset), .clr(1'b0), .inc(head_inc), .ptr(head), .wrap_c(head_wrap)
  );

  // Logical read index; held at 0 whenever idle so every operation starts from the oldest entry.
  seq_ptr_ctr #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_rd (
    .clk(clk), .reset(reset), .clr(idle), .inc(beat || (press && hit)),
    .ptr(rd_ptr), .wrap_c(rd_wrap)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (go_play)       state_nxt = ST_PLAY;
        else if (go_check) state_nxt = ST_CHECK;
      end
      ST_PLAY:  if (beat && last) state_nxt = ST_IDLE;
      ST_CHECK: if (press && (!hit || last)) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[wr_idx[IDX_W-1:0]] <= new_colour;
    end
  end

  // Length, drop indication and registered check result pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      seq_len        <= '0;
      overflow       <= 1'b0;
      check_match    <= 1'b0;
      check_mismatch <= 1'b0;
      check_done     <= 1'b0;
    end else begin
      overflow       <= 1'b0;
      check_match    <= 1'b0;
      check_mismatch <= 1'b0;
      check_done     <= 1'b0;
      if (load_ok && !full) seq_len <= seq_len + CNT_W'(1);
`ifndef SEQ_WRAP_EN
      if (load_ok && full) overflow <= 1'b1;
`endif
      if (press) begin
        check_match    <= hit;
        check_mismatch <= !hit;
        check_done     <= hit && last;
      end
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_seg
    logic [CNT_W-1:0] idx;
    assign idx = add_mod(head, CNT_W'(k));
    assign segment[k*COLOUR_W +: COLOUR_W] = mem[idx[IDX_W-1:0]];
  end

endmodule

// File: tb/tb_segment_sequence_store.sv
// Scoreboard bench for segment_sequence_store: directed loads, playback, checking and full handling.
module tb_segment_sequence_store;

  localparam int unsigned DEPTH = 33;
  localparam int unsigned CW    = 2;
  localparam int unsigned CNT_W = 6;

  logic                  clk = 1'b0;
  logic                  reset, load_colour, play_start, play_ready, check_start, check_valid;
  logic [CW-1:0]         new_colour, check_colour, play_colour;
  logic                  play_valid, play_last, check_match, check_mismatch, check_done;
  logic                  full, overflow;
  logic [CNT_W-1:0]      seq_len;
  logic [DEPTH*CW-1:0]   segment;

  typedef struct packed {logic [1:0] colour; logic last;} beat_t;
  beat_t      play_q[$];
  logic [2:0] chk_q[$];   // {match, mismatch, done}

  int n_checks = 0;
  int n_errors = 0;

  segment_sequence_store dut (
    .clk(clk), .reset(reset), .load_colour(load_colour), .new_colour(new_colour),
    .play_start(play_start), .play_valid(play_valid), .play_ready(play_ready),
    .play_colour(play_colour), .play_last(play_last), .check_start(check_start),
    .check_valid(check_valid), .check_colour(check_colour), .check_match(check_match),
    .check_mismatch(check_mismatch), .check_done(check_done), .seq_len(seq_len),
    .full(full), .overflow(overflow), .segment(segment)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic load(input logic [1:0] c);
    load_colour = 1'b1;
    new_colour  = c;
    tick();
    load_colour = 1'b0;
  endtask

  task automatic press(input logic [1:0] c, input logic [2:0] exp);
    check_valid  = 1'b1;
    check_colour = c;
    chk_q.push_back(exp);
    tick();
    check_valid = 1'b0;
  endtask

  function automatic logic [1:0] entry(input int k);
    return segment[k*CW +: CW];
  endfunction

  initial begin
    logic pat [4];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1};
    reset = 1'b1; load_colour = 1'b0; new_colour = '0; play_start = 1'b0; play_ready = 1'b0;
    check_start = 1'b0; check_valid = 1'b0; check_colour = '0;

    fork
      forever begin
        @(negedge clk);
        if (play_valid) begin
          if (play_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL play_unexpected: got colour %0d expected no beat", play_colour);
          end else begin
            chk(play_ready ? "play_beat" : "play_hold", 128'({play_colour, play_last}), 128'(play_q[0]));
            if (play_ready) void'(play_q.pop_front());
          end
        end
        if (check_match || check_mismatch || check_done) begin
          if (chk_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL check_unexpected: got %b expected no pulse", {check_match, check_mismatch, check_done});
          end else begin
            chk("check_result", 128'({check_match, check_mismatch, check_done}), 128'(chk_q.pop_front()));
          end
        end
      end
    join_none

    tick(); tick();
    chk("rst_seq_len", 128'(seq_len), 128'(0));
    chk("rst_full", 128'(full), 128'(0));
    chk("rst_overflow", 128'(overflow), 128'(0));
    chk("rst_play_valid", 128'(play_valid), 128'(0));
    chk("rst_segment", 128'(segment), 128'(0));
    chk("rst_pulses", 128'({check_match, check_mismatch, check_done}), 128'(0));
    reset = 1'b0;

    // Basic loading and a held-off load
    load(2'd2); load(2'd1); load(2'd3);
    chk("load_seq_len", 128'(seq_len), 128'(3));
    chk("load_segment", 128'(segment), 128'h36);
    chk("load_full", 128'(full), 128'(0));
    chk("load_overflow", 128'(overflow), 128'(0));
    new_colour = 2'd1;
    tick();
    chk("noload_seq_len", 128'(seq_len), 128'(3));
    do_reset();
    chk("midrst_seq_len", 128'(seq_len), 128'(0));
    chk("midrst_segment", 128'(segment), 128'(0));

    // Playback with ready toggling 1,0,1,1
    load(2'd2); load(2'd1); load(2'd3);
    play_q.push_back('{2'd2, 1'b0});
    play_q.push_back('{2'd1, 1'b0});
    play_q.push_back('{2'd3, 1'b1});
    play_start = 1'b1;
    tick();
    play_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      play_ready = pat[i];
      tick();
    end
    play_ready = 1'b0;
    chk("play_end_valid", 128'(play_valid), 128'(0));
    chk("play_seq_len", 128'(seq_len), 128'(3));

    // Press in IDLE must produce no pulse
    check_valid = 1'b1; check_colour = 2'd2;
    tick();
    check_valid = 1'b0;

    // Full match run
    check_start = 1'b1;
    tick();
    check_start = 1'b0;
    press(2'd2, 3'b100); press(2'd1, 3'b100); press(2'd3, 3'b101);
    tick();

    // Match then mismatch
    check_start = 1'b1;
    tick();
    check_start = 1'b0;
    press(2'd2, 3'b100); press(2'd0, 3'b010);
    tick();
    load(2'd0);
    chk("mismatch_idle_load", 128'(seq_len), 128'(4));

    // Fill to DEPTH and load once more
    do_reset();
    for (int k = 0; k < DEPTH; k++) load(2'((k + 1) % 4));
    chk("fill_seq_len", 128'(seq_len), 128'(DEPTH));
    chk("fill_full", 128'(full), 128'(1));
    load(2'd0);
`ifdef SEQ_WRAP_EN
    chk("wrap_overflow", 128'(overflow), 128'(0));
    chk("wrap_seq_len", 128'(seq_len), 128'(DEPTH));
    chk("wrap_entry_last", 128'(entry(DEPTH - 1)), 128'(0));
    chk("wrap_entry0", 128'(entry(0)), 128'(2));
    chk("wrap_entry31", 128'(entry(DEPTH - 2)), 128'(1));
`else
    chk("ovf_pulse", 128'(overflow), 128'(1));
    tick();
    chk("ovf_clear", 128'(overflow), 128'(0));
    chk("ovf_seq_len", 128'(seq_len), 128'(DEPTH));
    chk("ovf_entry0", 128'(entry(0)), 128'(1));
    chk("ovf_entry_last", 128'(entry(DEPTH - 1)), 128'(1));
`endif

    // Simultaneous load and play_start: play wins, load dropped
    do_reset();
    load(2'd2); load(2'd1);
    play_q.push_back('{2'd2, 1'b0});
    play_q.push_back('{2'd1, 1'b1});
    load_colour = 1'b1; new_colour = 2'd3; play_start = 1'b1;
    tick();
    load_colour = 1'b0; play_start = 1'b0;
    play_ready = 1'b1;
    tick(); tick();
    play_ready = 1'b0;
    chk("race_seq_len", 128'(seq_len), 128'(2));
    chk("race_play_valid", 128'(play_valid), 128'(0));

    for (int i = 0; i < 20 && (play_q.size() != 0 || chk_q.size() != 0); i++) tick();
    tick();
    chk("play_q_drained", 128'(play_q.size()), 128'(0));
    chk("chk_q_drained", 128'(chk_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/segment_sequence_store.md
Name: segment_sequence_store

Overview:
- Parametrised successor to the colour segment loader in the Simon Says datapath.
- Stores a colour sequence of up to DEPTH entries, appended one per load, and exposes the whole array.
- Adds two operations: valid/ready playback of the stored sequence toward the LED driver, and step-by-step checking of player input with match/mismatch/done pulses back to the game FSM.

Parameters:
- DEPTH, 33, maximum number of stored colours (>=2).
- COLOUR_W, 2, bits per colour entry.
- CNT_W, $clog2(DEPTH+1), width of length and pointer values.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; clears contents, pointers and FSM.
- load_colour  in  1  append new_colour this cycle.
- new_colour  in  COLOUR_W  colour to append.
- play_start  in  1  request playback of the stored sequence.
- play_valid  out  1  play_colour is valid.
- play_ready  in  1  consumer accepts the current beat.
- play_colour  out  COLOUR_W  colour for the current beat.
- play_last  out  1  current beat is the final entry.
- check_start  in  1  begin checking player input from entry 0.
- check_valid  in  1  check_colour carries one player press.
- check_colour  in  COLOUR_W  player colour.
- check_match  out  1  one-cycle pulse: the press matched.
- check_mismatch  out  1  one-cycle pulse: the press was wrong.
- check_done  out  1  one-cycle pulse: all seq_len entries matched.
- seq_len  out  CNT_W  number of stored entries.
- full  out  1  seq_len == DEPTH.
- overflow  out  1  one-cycle pulse: a load was dropped.
- segment  out  DEPTH*COLOUR_W  flat array in logical order; entry k occupies bits [k*COLOUR_W +: COLOUR_W], with entry 0 the oldest.

Behaviour:
- Reset:
  - Every entry, seq_len, pointers and all outputs are forced to 0; FSM goes to IDLE.
  - Reset wins over every other input in the same cycle. Reset during PLAY or CHECK aborts the operation with no done or last pulse.
- FSM states: IDLE, PLAY, CHECK.
- Loading:
  - Accepted only in IDLE, when load_colour=1 and not full. Entry[seq_len] <= new_colour and seq_len increments on the next edge.
  - load_colour in PLAY or CHECK is ignored, with no overflow pulse.
- IDLE -> PLAY:
  - Taken on play_start with seq_len>0; play_start with seq_len=0 is ignored.
  - If play_start and load_colour are both asserted, play_start wins and the load is dropped silently.
- PLAY:
  - play_valid=1 from the first cycle in PLAY. play_colour = entry[rd_ptr], with rd_ptr starting at 0.
  - A beat completes when play_valid && play_ready; rd_ptr then increments. play_colour must stay stable while ready is low.
  - play_last = play_valid && (rd_ptr == seq_len-1). Handshake on the last beat returns to IDLE next cycle with play_valid=0.
  - play_start and check_start are ignored in PLAY.
- IDLE -> CHECK:
  - Taken on check_start with seq_len>0. rd_ptr <= 0.
  - check_start takes priority below play_start if both are asserted.
- CHECK:
  - Each check_valid compares check_colour with entry[rd_ptr]. The result pulse appears one cycle later (registered).
  - Match: check_match=1 and rd_ptr increments. If it was the final entry, check_done=1 in the same cycle as check_match and the FSM returns to IDLE.
  - Mismatch: check_mismatch=1 and the FSM returns to IDLE.
  - check_valid in IDLE or PLAY is ignored. match and mismatch are never asserted together.
- Full: a load attempt in IDLE while full is handled per SEQ_WRAP_EN.
- seq_len, full and segment update on the edge after an accepted load. full is combinational from seq_len.

Optional Feature:
- Macro: SEQ_WRAP_EN.
- Defined:
  - The memory is circular with a head pointer. A load while full overwrites the oldest entry and advances head; seq_len stays DEPTH and overflow stays 0.
  - segment, playback and check all index from head (logical order).
- Undefined:
  - head is fixed at 0. A load while full is dropped, overflow pulses for one cycle, and contents are unchanged.

Decomposition:
- Package seq_store_pkg: state enum seq_state_e {IDLE, PLAY, CHECK} and a colour_t typedef for COLOUR_W=2 (RED, GREEN, BLUE, YELLOW = 0..3).
- The pointer/index math is local.
- One natural sub-module, seq_ptr_ctr: a modulo-DEPTH pointer with inc, clr and wrap flag, instantiated for head and rd_ptr.

Test Plan:
- Reset, then load 2,1,3 -> seq_len=3; segment[5:0]=6'b11_01_10; full=0; overflow=0.
- Load 1 with load_colour=0 for one cycle -> seq_len unchanged at 3. Pulse reset mid-sequence -> seq_len=0 and segment all 0.
- Load 2,1,3, then play_start with play_ready toggling 1,0,1,1 -> beats 2,1,3 in order; colour held while ready=0; play_last only on 3; then IDLE with play_valid=0.
- Load 2,1,3, check_start, press 2,1,3 -> three check_match pulses, check_done coincident with the third. Repeat with presses 2,0 -> match then mismatch, back in IDLE.
- Fill DEPTH=33 entries, then load 0:
  - Without SEQ_WRAP_EN: overflow=1 for one cycle, seq_len=33, entry 0 unchanged.
  - With SEQ_WRAP_EN: overflow=0, entry 32 (logical) = 0, logical entry 0 = former entry 1.
- load_colour and play_start asserted in the same cycle with seq_len=2 -> playback of 2 beats, seq_len remains 2.
